// File: rtl/sec_locator_seq.sv
// sec_locator_seq: bit-serial AN-code single-error locator/corrector.
// Reduces the received codeword mod A one bit per cycle, MSB first. It then walks
// the powers of two mod A to find which bit position, and which sign, explains the
// remainder. The corrected codeword is returned over a valid/ready handshake.
module sec_locator_seq #(
  parameter int A    = 655,
  parameter int CW   = 14,
  parameter int RW   = 10,
  parameter int NLOC = 14,
  parameter int LW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_cw,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_cw,
  output logic [LW-1:0] out_l,
  output logic [RW-1:0] out_r,
  output logic          out_due
);

  localparam int CNTW = $clog2(CW + 1);
  localparam int KW   = $clog2(NLOC + 1);
  localparam logic [RW:0]   a_ext = (RW + 1)'(A);
  localparam logic [RW-1:0] a_rw  = RW'(A);

  typedef enum logic [1:0] {IDLE, MOD, SEARCH, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cw_reg;
  logic [CW-1:0]   sh_reg;
  logic [RW-1:0]   r_reg;
  logic [RW-1:0]   p_reg;
  logic [KW-1:0]   k_reg;
  logic [CNTW-1:0] cnt_reg;

  logic [RW:0]     r_dbl;
  logic [RW-1:0]   r_mod_next;
  logic [RW:0]     p_dbl;
  logic [RW-1:0]   p_next;
  logic [RW-1:0]   r_neg;
  logic [CW-1:0]   pow;

  // Next-step arithmetic: one remainder bit, one doubling of p, the negated remainder, 2^(k-1).
  always_comb begin
    r_dbl      = {r_reg, 1'b0} | {{RW{1'b0}}, sh_reg[CW-1]};
    r_mod_next = (r_dbl >= a_ext) ? RW'(r_dbl - a_ext) : RW'(r_dbl);
    p_dbl      = {p_reg, 1'b0};
    p_next     = (p_dbl >= a_ext) ? RW'(p_dbl - a_ext) : RW'(p_dbl);
    r_neg      = a_rw - r_reg;
    pow        = CW'(1) << (k_reg - 1'b1);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cw_reg    <= '0;
      sh_reg    <= '0;
      r_reg     <= '0;
      p_reg     <= '0;
      k_reg     <= '0;
      cnt_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_cw    <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_due   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            cw_reg    <= in_cw;
            sh_reg    <= in_cw;
            r_reg     <= '0;
            cnt_reg   <= CNTW'(CW);
            in_ready  <= 1'b0;
            state_reg <= MOD;
          end
        end
        MOD: begin
          // CW cycles shift in the bits; one extra cycle decides clean vs search.
          if (cnt_reg != '0) begin
            r_reg   <= r_mod_next;
            sh_reg  <= sh_reg << 1;
            cnt_reg <= cnt_reg - 1'b1;
          end else if (r_reg == '0) begin
            out_r     <= '0;
            out_l     <= '0;
            out_due   <= 1'b0;
            out_cw    <= cw_reg;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            p_reg     <= RW'(1);
            k_reg     <= KW'(1);
            state_reg <= SEARCH;
          end
        end
        SEARCH: begin
          // +k is tested first; for a legal A at most one of +k/-k can hit.
          if (p_reg == r_reg) begin
            out_r     <= r_reg;
            out_l     <= LW'(k_reg);
            out_due   <= 1'b0;
            out_cw    <= cw_reg - pow;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else if (p_reg == r_neg) begin
            out_r     <= r_reg;
            out_l     <= -LW'(k_reg);
            out_due   <= 1'b0;
            out_cw    <= cw_reg + pow;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else if (k_reg == KW'(NLOC)) begin
            out_r     <= r_reg;
            out_l     <= '0;
            out_due   <= 1'b1;
            out_cw    <= cw_reg;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            p_reg <= p_next;
            k_reg <= k_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sec_locator_seq.sv
// tb_sec_locator_seq: directed checks of sec_locator_seq with hand-computed results.
module tb_sec_locator_seq;

  localparam int CW = 14;
  localparam int RW = 10;
  localparam int LW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_cw;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_cw;
  logic [LW-1:0] out_l;
  logic [RW-1:0] out_r;
  logic          out_due;

  int tests;
  int fails;

  sec_locator_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cw     (in_cw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cw    (out_cw),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_due   (out_due)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one codeword, then count rising edges after the accept edge until out_valid.
  task automatic send_and_wait(input logic [CW-1:0] cw, output int lat, output bit timeout);
    @(negedge clk);
    in_cw    = cw;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    timeout  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        timeout = 1'b0;
        break;
      end
    end
    $display("[TB] op cw=%0d -> r=%0d l=%0d due=%0d cw_out=%0d latency=%0d",
             cw, out_r, $signed(out_l), out_due, out_cw, lat);
  endtask

  // Pulse out_ready for one edge to consume the held result.
  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    tests++; if (out_cw !== '0) begin fails++; $display("FAIL reset_out_cw: got %0d expected 0", out_cw); end
    tests++; if (out_l !== '0) begin fails++; $display("FAIL reset_out_l: got %0d expected 0", out_l); end
    tests++; if (out_r !== '0) begin fails++; $display("FAIL reset_out_r: got %0d expected 0", out_r); end
    tests++; if (out_due !== 1'b0) begin fails++; $display("FAIL reset_out_due: got %0b expected 0", out_due); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    int lat;
    bit to;
    send_and_wait(14'd3275, lat, to);
    tests++; if (to) begin fails++; $display("FAIL clean_timeout: got no out_valid expected latency 15"); end
    tests++; if (lat !== 15) begin fails++; $display("FAIL clean_latency: got %0d expected 15", lat); end
    tests++; if (out_r !== 10'd0) begin fails++; $display("FAIL clean_r: got %0d expected 0", out_r); end
    tests++; if (out_l !== 5'd0) begin fails++; $display("FAIL clean_l: got %0d expected 0", out_l); end
    tests++; if (out_due !== 1'b0) begin fails++; $display("FAIL clean_due: got %0b expected 0", out_due); end
    tests++; if (out_cw !== 14'd3275) begin fails++; $display("FAIL clean_cw: got %0d expected 3275", out_cw); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL clean_in_ready: got %0b expected 0", in_ready); end
    take_result();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clean_release_valid: got %0b expected 0", out_valid); end
  endtask

  // One correctable single-bit error; expected values come from the caller's table row.
  task automatic test_correct(input string name, input logic [CW-1:0] cw, input logic [RW-1:0] exp_r,
                              input logic [LW-1:0] exp_l, input logic [CW-1:0] exp_cw, input int exp_lat);
    int lat;
    bit to;
    send_and_wait(cw, lat, to);
    tests++; if (to) begin fails++; $display("FAIL %s_timeout: got no out_valid expected latency %0d", name, exp_lat); end
    tests++; if (lat !== exp_lat) begin fails++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    tests++; if (out_r !== exp_r) begin fails++; $display("FAIL %s_r: got %0d expected %0d", name, out_r, exp_r); end
    tests++; if (out_l !== exp_l) begin fails++; $display("FAIL %s_l: got %0d expected %0d", name, $signed(out_l), $signed(exp_l)); end
    tests++; if (out_due !== 1'b0) begin fails++; $display("FAIL %s_due: got %0b expected 0", name, out_due); end
    tests++; if (out_cw !== exp_cw) begin fails++; $display("FAIL %s_cw: got %0d expected %0d", name, out_cw, exp_cw); end
    take_result();
  endtask

  task automatic test_due();
    int lat;
    bit to;
    send_and_wait(14'd1313, lat, to);
    tests++; if (to) begin fails++; $display("FAIL due_timeout: got no out_valid expected latency 29"); end
    tests++; if (lat !== 29) begin fails++; $display("FAIL due_latency: got %0d expected 29", lat); end
    tests++; if (out_r !== 10'd3) begin fails++; $display("FAIL due_r: got %0d expected 3", out_r); end
    tests++; if (out_l !== 5'd0) begin fails++; $display("FAIL due_l: got %0d expected 0", out_l); end
    tests++; if (out_due !== 1'b1) begin fails++; $display("FAIL due_flag: got %0b expected 1", out_due); end
    tests++; if (out_cw !== 14'd1313) begin fails++; $display("FAIL due_cw: got %0d expected 1313", out_cw); end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    send_and_wait(14'd3276, lat, to);
    tests++; if (to) begin fails++; $display("FAIL bp_timeout: got no out_valid expected latency 16"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_cw    = 14'd1313;
      @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %0b expected 1", c, out_valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", c, in_ready); end
      tests++; if (out_cw !== 14'd3275) begin fails++; $display("FAIL bp_cw[%0d]: got %0d expected 3275", c, out_cw); end
      tests++; if (out_l !== 5'd1) begin fails++; $display("FAIL bp_l[%0d]: got %0d expected 1", c, out_l); end
      tests++; if (out_r !== 10'd1) begin fails++; $display("FAIL bp_r[%0d]: got %0d expected 1", c, out_r); end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %0b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %0b expected 0", out_valid); end
    $display("[TB] backpressure released: in_ready=%0b out_valid=%0b", in_ready, out_valid);
  endtask

  task automatic test_reset_mid();
    // 2251 searches 11 locations, so 20 edges after accept lands inside SEARCH.
    @(negedge clk);
    in_cw    = 14'd2251;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %0b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %0b expected 0", out_valid); end
    tests++; if (out_cw !== '0) begin fails++; $display("FAIL midrst_cw: got %0d expected 0", out_cw); end
    tests++; if (out_r !== '0) begin fails++; $display("FAIL midrst_r: got %0d expected 0", out_r); end
    tests++; if (out_l !== '0) begin fails++; $display("FAIL midrst_l: got %0d expected 0", out_l); end
    tests++; if (out_due !== 1'b0) begin fails++; $display("FAIL midrst_due: got %0b expected 0", out_due); end
    $display("[TB] reset during search: in_ready=%0b out_valid=%0b", in_ready, out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    test_correct("after_rst", 14'd3276, 10'd1, 5'd1, 14'd3275, 16);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b0;
    test_reset();
    test_clean();
    test_correct("plus1", 14'd3276, 10'd1, 5'd1, 14'd3275, 16);
    test_correct("minus11", 14'd2251, 10'd286, 5'b10101, 14'd3275, 26);
    test_correct("plus14", 14'd8847, 10'd332, 5'd14, 14'd655, 29);
    test_due();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
